// File: rtl/shift_feeder.sv
// Parallel-to-serial feeder for the downstream shift register.
// A one-entry holding buffer lets words stream with no idle cycles; GAP adds idle spacing per word.
module shift_feeder #(
  parameter int WIDTH = 16,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             d,
  output logic             en,
  output logic             dir,
  output logic             word_done,
  output logic             busy
);
  // state    | meaning
  // ST_IDLE  | no active word; a held word loads on the next edge
  // ST_SHIFT | one bit per cycle on d with en=1
  // ST_GAP   | en=0 spacing after a word, counted down to zero
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_e;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [3:0]    GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_e           state_q, state_d;
  logic             hold_valid_q, hold_valid_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;
  logic             hold_dir_q, hold_dir_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       gap_q, gap_d;
  logic             d_q, d_d;
  logic             en_q, en_d;
  logic             dir_q, dir_d;
  logic             wd_q, wd_d;
  logic             busy_q, busy_d;
  logic             load;

  // Bit driven on the c-th shift cycle of a word.
  function automatic logic bit_at(input logic [WIDTH-1:0] w, input logic dr,
                                  input logic [CW-1:0] c);
    logic [CW-1:0] idx;
    idx = dr ? c : (CNT_LAST - c);
    return w[idx];
  endfunction

  always_comb begin
    state_d      = state_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    hold_dir_d   = hold_dir_q;
    word_d       = word_q;
    cnt_d        = cnt_q;
    gap_d        = gap_q;
    dir_d        = dir_q;
    d_d          = 1'b0;
    en_d         = 1'b0;
    wd_d         = 1'b0;
    load         = 1'b0;

    if (in_valid && !hold_valid_q) begin
      hold_valid_d = 1'b1;
      hold_data_d  = in_data;
      hold_dir_d   = in_dir;
    end

    case (state_q)
      ST_IDLE: load = hold_valid_q;
      ST_SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          if (GAP > 0) begin
            state_d = ST_GAP;
            gap_d   = GAP_LAST;
          end else if (hold_valid_q) begin
            load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          en_d  = 1'b1;
          d_d   = bit_at(word_q, dir_q, cnt_d);
          wd_d  = (cnt_d == CNT_LAST);
        end
      end
      ST_GAP: begin
        if (gap_q == 4'd0) begin
          if (hold_valid_q) load = 1'b1;
          else              state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Load drains the buffer; capture above cannot fire on the same edge since hold_valid_q=1.
    if (load) begin
      state_d      = ST_SHIFT;
      word_d       = hold_data_q;
      dir_d        = hold_dir_q;
      cnt_d        = '0;
      hold_valid_d = 1'b0;
      en_d         = 1'b1;
      d_d          = bit_at(hold_data_q, hold_dir_q, '0);
      wd_d         = 1'b0;
    end

    busy_d = (state_d != ST_IDLE) || hold_valid_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      hold_dir_q   <= 1'b0;
      word_q       <= '0;
      cnt_q        <= '0;
      gap_q        <= '0;
      d_q          <= 1'b0;
      en_q         <= 1'b0;
      dir_q        <= 1'b0;
      wd_q         <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      hold_dir_q   <= hold_dir_d;
      word_q       <= word_d;
      cnt_q        <= cnt_d;
      gap_q        <= gap_d;
      d_q          <= d_d;
      en_q         <= en_d;
      dir_q        <= dir_d;
      wd_q         <= wd_d;
      busy_q       <= busy_d;
    end
  end

  assign in_ready  = !hold_valid_q;
  assign d         = d_q;
  assign en        = en_q;
  assign dir       = dir_q;
  assign word_done = wd_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_shift_feeder.sv
// Bench for shift_feeder: two lanes (GAP=0 and GAP=3) fed identical stimulus and
// compared cycle by cycle against a timeline model built from load-edge arithmetic.
module tb_shift_feeder;
  localparam int W    = 16;
  localparam int MAXC = 4096;

  typedef struct {
    logic [W-1:0] data;
    logic         dir;
    int           dly;
    bit           mark;
  } stim_t;

  logic clk = 1'b0;
  logic rstn;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] in_data_a [2];
  logic         in_dir_a   [2];
  logic         in_valid_a [2];
  logic         in_ready_o [2];
  logic         d_o        [2];
  logic         en_o       [2];
  logic         dir_o      [2];
  logic         wd_o       [2];
  logic         busy_o     [2];
  logic [W-1:0] dn_out     [2];

  bit           exp_en   [2][MAXC];
  bit           exp_d    [2][MAXC];
  bit           exp_dir  [2][MAXC];
  bit           exp_wd   [2][MAXC];
  bit           exp_busy [2][MAXC];
  bit           exp_hold [2][MAXC];
  logic [W-1:0] exp_wv   [2][MAXC];
  int           next_free [2];
  bit           have_a    [2];
  stim_t        sq0[$];
  stim_t        sq1[$];
  int           mark_load = -1;
  int           n_checks  = 0;
  int           n_fail    = 0;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int GP = (g == 0) ? 0 : 3;
    logic [W-1:0] dn;
    shift_feeder #(.WIDTH(W), .GAP(GP)) u_dut (
      .clk      (clk),
      .rstn     (rstn),
      .in_data  (in_data_a[g]),
      .in_dir   (in_dir_a[g]),
      .in_valid (in_valid_a[g]),
      .in_ready (in_ready_o[g]),
      .d        (d_o[g]),
      .en       (en_o[g]),
      .dir      (dir_o[g]),
      .word_done(wd_o[g]),
      .busy     (busy_o[g])
    );
    // Behavioural downstream register
    always @(posedge clk or negedge rstn) begin
      if (!rstn)          dn <= '0;
      else if (en_o[g])   dn <= dir_o[g] ? {d_o[g], dn[W-1:1]} : {dn[W-2:0], d_o[g]};
    end
    assign dn_out[g] = dn;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic int gap_of(input int g);
    return (g == 0) ? 0 : 3;
  endfunction

  // Word accepted at edge k loads at max(k+1, end of previous word incl. gap).
  task automatic schedule(input int g, input int k, input stim_t s);
    int l;
    int gp;
    gp = gap_of(g);
    l = (k + 1 > next_free[g]) ? k + 1 : next_free[g];
    next_free[g] = l + W + gp;
    if (s.mark && g == 0) mark_load = l;
    for (int i = k; i < l; i++) if (i < MAXC) exp_hold[g][i] = 1'b1;
    for (int i = l; i < l + W + gp; i++) if (i < MAXC) exp_busy[g][i] = 1'b1;
    for (int i = 0; i < W; i++) begin
      int pos;
      pos = s.dir ? i : W - 1 - i;
      if (l + i < MAXC) begin
        exp_en[g][l+i]  = 1'b1;
        exp_d[g][l+i]   = s.data[pos];
        exp_dir[g][l+i] = s.dir;
      end
    end
    if (l + W - 1 < MAXC) begin
      exp_wd[g][l+W-1] = 1'b1;
      exp_wv[g][l+W-1] = s.data;
    end
  endtask

  task automatic clear_from(input int g, input int c);
    for (int i = c; i < MAXC; i++) begin
      exp_en[g][i]   = 1'b0;
      exp_d[g][i]    = 1'b0;
      exp_dir[g][i]  = 1'b0;
      exp_wd[g][i]   = 1'b0;
      exp_busy[g][i] = 1'b0;
      exp_hold[g][i] = 1'b0;
    end
    next_free[g] = 0;
  endtask

  task automatic run_lane(input int g);
    stim_t cur;
    int    dly;
    int    e;
    string p;
    dly = 0;
    p = $sformatf("l%0d_", g);
    in_valid_a[g] = 1'b0;
    in_data_a[g]  = '0;
    in_dir_a[g]   = 1'b0;
    forever begin
      @(negedge clk);
      e = cyc;
      if (e >= MAXC) continue;
      if (!rstn) begin
        check_val({p, "rst_en"},    32'(en_o[g]),       32'd0);
        check_val({p, "rst_d"},     32'(d_o[g]),        32'd0);
        check_val({p, "rst_dir"},   32'(dir_o[g]),      32'd0);
        check_val({p, "rst_wd"},    32'(wd_o[g]),       32'd0);
        check_val({p, "rst_busy"},  32'(busy_o[g]),     32'd0);
        check_val({p, "rst_ready"}, 32'(in_ready_o[g]), 32'd1);
        clear_from(g, e);
        have_a[g]     = 1'b0;
        in_valid_a[g] = 1'b1;
        in_data_a[g]  = W'($urandom);
        in_dir_a[g]   = 1'($urandom);
        continue;
      end
      check_val({p, "en"},    32'(en_o[g]),       32'(exp_en[g][e]));
      check_val({p, "d"},     32'(d_o[g]),        32'(exp_d[g][e]));
      check_val({p, "wd"},    32'(wd_o[g]),       32'(exp_wd[g][e]));
      check_val({p, "busy"},  32'(busy_o[g]),     32'(exp_busy[g][e] | exp_hold[g][e]));
      check_val({p, "ready"}, 32'(in_ready_o[g]), 32'(!exp_hold[g][e]));
      if (exp_en[g][e]) check_val({p, "dir"}, 32'(dir_o[g]), 32'(exp_dir[g][e]));
      if (e > 0 && exp_wd[g][e-1]) check_val({p, "dn_out"}, 32'(dn_out[g]), 32'(exp_wv[g][e-1]));

      if (!have_a[g]) begin
        if (g == 0 && sq0.size() > 0) begin cur = sq0.pop_front(); have_a[g] = 1'b1; dly = cur.dly; end
        if (g == 1 && sq1.size() > 0) begin cur = sq1.pop_front(); have_a[g] = 1'b1; dly = cur.dly; end
      end
      if (have_a[g] && dly == 0) begin
        in_valid_a[g] = 1'b1;
        in_data_a[g]  = cur.data;
        in_dir_a[g]   = cur.dir;
        if (!exp_hold[g][e]) begin
          schedule(g, e + 1, cur);
          have_a[g] = 1'b0;
        end
      end else begin
        if (have_a[g]) dly--;
        in_valid_a[g] = 1'b0;
        in_data_a[g]  = W'($urandom);
        in_dir_a[g]   = 1'($urandom);
      end
    end
  endtask

  task automatic push_both(input logic [W-1:0] data, input logic dr, input int dly, input bit mark);
    stim_t s;
    s.data = data; s.dir = dr; s.dly = dly; s.mark = mark;
    sq0.push_back(s);
    sq1.push_back(s);
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      @(posedge clk); #1;
      done = (sq0.size() == 0) && (sq1.size() == 0) && !have_a[0] && !have_a[1] &&
             (cyc > next_free[0]) && (cyc > next_free[1]);
    end
    check_val("drain", 32'(done), 32'd1);
  endtask

  initial begin
    bit found;
    rstn = 1'b1;
    #1 rstn = 1'b0;
    fork
      run_lane(0);
      run_lane(1);
    join_none
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;

    push_both(16'hA5C3, 1'b0, 0, 1'b0);
    push_both(16'h0001, 1'b1, 2, 1'b0);
    push_both(16'hFFFF, 1'b0, 3, 1'b0);
    push_both(16'h0000, 1'b1, 0, 1'b0);
    push_both(16'hC3A5, 1'b1, 0, 1'b0);
    wait_idle(600);

    // Reset while bit 7 of 16'h1234 is on d and a second word sits in the buffer.
    push_both(16'h1234, 1'b0, 2, 1'b1);
    push_both(16'h5A5A, 1'b1, 0, 1'b0);
    found = 1'b0;
    for (int n = 0; n < 400 && !found; n++) begin
      @(posedge clk); #1;
      if (mark_load >= 0 && cyc == mark_load + 7) found = 1'b1;
    end
    check_val("mark_seen", 32'(found), 32'd1);
    #1 rstn = 1'b0;
    sq0.delete();
    sq1.delete();
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;

    push_both(16'h8001, 1'b0, 1, 1'b0);
    wait_idle(200);

    for (int i = 0; i < 60; i++)
      push_both(W'($urandom), 1'($urandom),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 0, 1'b0);
    wait_idle(2500);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/shift_feeder.md
Name: shift_feeder

Overview:
Upstream stage of the 16-bit serial shift register. Accepts parallel words plus a per-word direction bit over a valid/ready handshake and serializes each word onto the register's d/en/dir inputs, one bit per clock. It includes a one-entry holding buffer so that words can stream with no idle cycles. After WIDTH enabled shifts, the downstream register's out equals the submitted word.

Parameters:
WIDTH, 16, word width in bits; must be at least 2; must match the downstream register MSB parameter.
GAP, 0, number of idle cycles (en=0) inserted after every word; 0 to 15.

Ports:
clk  input  1  system clock; all state changes on posedge.
rstn  input  1  asynchronous active-low reset.
in_data  input  WIDTH  parallel word to serialize.
in_dir  input  1  direction for this word: 0 = MSB-first, 1 = LSB-first.
in_valid  input  1  in_data/in_dir are valid.
in_ready  output  1  holding buffer empty, so the block can accept a word.
d  output  1  serial bit to the downstream d input.
en  output  1  shift enable to the downstream register.
dir  output  1  direction to the downstream register, held for the whole word.
word_done  output  1  one-cycle pulse coincident with the last bit of a word.
busy  output  1  high while a word is active, in GAP, or held.

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is asynchronous and active-low.
- Reset values: d=0, en=0, dir=0, word_done=0, busy=0. The holding buffer, bit counter and gap counter all clear, and the FSM goes to IDLE.
- in_ready is combinational: in_ready = !hold_valid. It reads 1 during reset, but no transfer occurs while rstn=0.
- Accept: on a posedge with in_valid && in_ready, in_data and in_dir are captured into the holding buffer and hold_valid is set.
- All of d, en, dir, word_done and busy are registered outputs.
- FSM states: IDLE, SHIFT, GAP.
- IDLE: en=0 and d=0.
  - If hold_valid, the next edge moves the held word into the active shift register, loads dir, clears the counter, clears hold_valid and goes to SHIFT.
  - Latency: word accepted at edge k, first bit driven after edge k+1, downstream samples it at edge k+2.
- SHIFT: en=1 for exactly WIDTH consecutive cycles.
  - dir=0: d = bit WIDTH-1, then WIDTH-2, down to bit 0.
  - dir=1: d = bit 0, then 1, up to bit WIDTH-1.
  - The counter runs 0 to WIDTH-1, with width $clog2(WIDTH).
  - word_done=1 only in the cycle the last bit is driven.
- End of word (at the edge ending the last bit):
  - GAP=0 and hold_valid: load the next word directly and stay in SHIFT. en stays continuously high, and dir may change at this boundary.
  - GAP=0 and no held word: go to IDLE.
  - GAP>0: go to GAP.
- GAP: en=0 and d=0 for exactly GAP cycles, then behave as IDLE. If a word is held, the load edge is the one that ends the last GAP cycle.
- Buffer timing: the holding buffer is drained at the load edge and may be refilled from the following edge. A new word may be accepted during SHIFT or GAP.
- Buffer full: in_ready=0 while a word is held; in_valid is ignored and upstream must hold its data stable.
- in_data/in_dir changes while in_ready=0 have no effect.
- busy = (state != IDLE) || hold_valid.
- Reset mid-word: all outputs return to reset values immediately. The partial word and any held word are discarded and no word_done is issued. Operation after reset is clean from IDLE.
- dir never changes while en=1 except at a word boundary.

Test Plan:
- Reset: hold rstn=0 for 2 cycles with in_valid=1 -> d=en=dir=word_done=busy=0 and in_ready=1; no word is captured.
- Single word, MSB-first: in_data=16'hA5C3, in_dir=0, accepted at edge k.
  - en=1 for exactly 16 cycles starting after edge k+1.
  - d = 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1.
  - word_done high only on the 16th bit; the downstream out then equals 16'hA5C3.
- LSB-first: in_data=16'h0001, in_dir=1 -> dir=1 for the whole word; d=1 on the first bit then 15 zeros.
- Back-to-back, GAP=0: send 16'hFFFF (dir=0) then 16'h0000 (dir=1) with in_valid held high.
  - en stays high for 32 consecutive cycles.
  - dir changes 0->1 exactly at bit 17.
  - in_ready is low while the second word is held.
  - Two word_done pulses, 16 cycles apart.
- GAP=3: send two words back-to-back -> en is low for exactly 3 cycles between them with d=0; busy stays 1 throughout.
- Mid-word reset: assert rstn=0 during bit 7 of 16'h1234 while a second word is held.
  - Outputs clear asynchronously; no word_done is issued.
  - After release, the held word is not sent.
  - A new word 16'h8001 (dir=0) then serializes correctly from bit 15.
